// File: rtl/gg_text_loader_if.sv
// Download-channel and code-bus signal bundle for the Game Genie text loader.
// The master side is the HPS download source plus the code-bus observer;
// the slave side is the loader itself.
interface gg_text_loader_if;
    logic        dl_active;
    logic        dl_wr;
    logic [7:0]  dl_data;
    logic        dl_wait;
    logic [37:0] code;
    logic [3:0]  code_count;
    logic [3:0]  bad_count;
    logic        overflow;

    modport master (
        output dl_active, dl_wr, dl_data,
        input  dl_wait, code, code_count, bad_count, overflow
    );

    modport slave (
        input  dl_active, dl_wr, dl_data,
        output dl_wait, code, code_count, bad_count, overflow
    );
endinterface

// File: rtl/gg_text_loader.sv
// Game Genie text loader: parses an ASCII cheat stream, decodes 6/8-letter
// codes and drives one-cycle frames onto the code bus. Every download starts
// by clearing all evaluator slots.
module gg_text_loader #(
    parameter int MAX_CODES = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    gg_text_loader_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(MAX_CODES - 1);
    localparam logic [3:0] MAX_CNT  = 4'(MAX_CODES);

    // Map a byte to {is_letter, nibble}; lower case folds onto upper case.
    function automatic logic [4:0] letter_val(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        case (u)
            8'h41:   return 5'h10; // A
            8'h50:   return 5'h11; // P
            8'h5A:   return 5'h12; // Z
            8'h4C:   return 5'h13; // L
            8'h47:   return 5'h14; // G
            8'h49:   return 5'h15; // I
            8'h54:   return 5'h16; // T
            8'h59:   return 5'h17; // Y
            8'h45:   return 5'h18; // E
            8'h4F:   return 5'h19; // O
            8'h58:   return 5'h1A; // X
            8'h55:   return 5'h1B; // U
            8'h4B:   return 5'h1C; // K
            8'h53:   return 5'h1D; // S
            8'h56:   return 5'h1E; // V
            8'h4E:   return 5'h1F; // N
            default: return 5'h00;
        endcase
    endfunction

    // Token separators: LF, CR, space, comma, semicolon.
    function automatic logic is_sep(input logic [7:0] c);
        return (c == 8'h0A) || (c == 8'h0D) || (c == 8'h20) ||
               (c == 8'h2C) || (c == 8'h3B);
    endfunction

    // Saturating 4-bit increment for the malformed-code counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [1:0]       state_q, state_d;
    logic             act_q;
    logic [3:0]       idx_q, idx_d;
    logic [7:0][3:0]  nib_q, nib_d;
    logic [3:0]       len_q, len_d;
    logic             inv_q, inv_d;
    logic [37:0]      code_q, code_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       bad_q, bad_d;
    logic             ovf_q, ovf_d;
    logic             wait_q, wait_d;

    logic [4:0]       ltr;
    logic             sep;
    logic             rise;
    logic             accept;
    logic             len8;
    logic [14:0]      addr;
    logic [7:0]       cmp;
    logic [7:0]       rep;

    assign ltr  = letter_val(bus.dl_data);
    assign sep  = is_sep(bus.dl_data);
    assign rise = bus.dl_active & ~act_q;

    // Bytes are taken only while collecting, when not stalled, and while the
    // download is active or on the very edge where it ends.
    assign accept = bus.dl_wr & ~wait_q & (bus.dl_active | act_q) &
                    (state_q == S_COLLECT);

    // Letter-to-field scramble; address bit 15 is implied by the evaluator.
    assign len8 = (len_q == 4'd8);
    assign addr = {nib_q[3][2:0], nib_q[4][3], nib_q[5][2:0], nib_q[1][3],
                   nib_q[2][2:0], nib_q[3][3], nib_q[4][2:0]};
    assign cmp  = len8 ? {nib_q[6][3], nib_q[7][2:0], nib_q[5][3], nib_q[6][2:0]}
                       : 8'h00;
    assign rep  = {nib_q[0][3], nib_q[1][2:0],
                   (len8 ? nib_q[7][3] : nib_q[5][3]), nib_q[0][2:0]};

    // Parser next-state: clear sweep, token collection and token resolution.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nib_d   = nib_q;
        len_d   = len_q;
        inv_d   = inv_q;
        code_d  = '0;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        wait_d  = 1'b0;

        if (rise) begin
            // A new download always restarts from the slot sweep and drops
            // any half-collected token.
            state_d = S_CLEAR;
            idx_d   = 4'd0;
            cnt_d   = 4'd0;
            bad_d   = 4'd0;
            ovf_d   = 1'b0;
            nib_d   = '0;
            len_d   = 4'd0;
            inv_d   = 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    code_d = {1'b1, idx_q, 33'd0};
                    wait_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COLLECT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (sep) begin
                            state_d = S_EMIT;
                            wait_d  = 1'b1;
                        end else if (!inv_q) begin
                            if (!ltr[4] || len_q == 4'd8) begin
                                inv_d = 1'b1;
                            end else begin
                                nib_d[len_q[2:0]] = ltr[3:0];
                                len_d = len_q + 4'd1;
                            end
                        end
                    end else if (!bus.dl_active) begin
                        // End of download flushes the pending token.
                        state_d = S_EMIT;
                        wait_d  = 1'b1;
                    end
                end
                S_EMIT: begin
                    if (len_q == 4'd0 && !inv_q) begin
                        // Empty token: nothing to report.
                    end else if (inv_q || (len_q != 4'd6 && len_q != 4'd8)) begin
                        bad_d = sat_inc4(bad_q);
                    end else if (cnt_q == MAX_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        code_d = {1'b1, cnt_q, 1'b1, len8, addr, cmp, rep};
                        cnt_d  = cnt_q + 4'd1;
                    end
                    nib_d   = '0;
                    len_d   = 4'd0;
                    inv_d   = 1'b0;
                    state_d = bus.dl_active ? S_COLLECT : S_IDLE;
                end
                default: begin
                    // Idle: only a dl_active rise leaves this state.
                end
            endcase
        end
    end

    // State and output registers; reset drops any frame in flight at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            idx_q   <= 4'd0;
            nib_q   <= '0;
            len_q   <= 4'd0;
            inv_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= 4'd0;
            bad_q   <= 4'd0;
            ovf_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= bus.dl_active;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            len_q   <= len_d;
            inv_q   <= inv_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.dl_wait    = wait_q;
    assign bus.code_count = cnt_q;
    assign bus.bad_count  = bad_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: doc/gg_text_loader.md
# gg_text_loader

Transmitter for the Game Genie code bus: parses an ASCII cheat text stream delivered by the HPS file-download channel, decodes each 6- or 8-letter Game Genie code into address/compare/replace fields, and sends one-cycle code-bus frames to the code evaluator. It replaces ROM-driven code entry with menu/file-driven entry. It also clears stale evaluator slots at the start of every download.

## Interface
- MAX_CODES, 9, number of evaluator slots (1..15); also the number of clear frames sent.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- dl_active  in  1  high for the duration of a cheat-file download
- dl_wr  in  1  one-cycle strobe: dl_data valid
- dl_data  in  8  ASCII byte
- dl_wait  out  1  high: source must not strobe dl_wr
- code  out  38  frame {clock bit[37], index[36:33], enable[32], compare enable[31], addr[30:16], compare[15:8], replace[7:0]}; zero when idle
- code_count  out  4  codes sent in current download
- bad_count  out  4  malformed codes dropped, saturating at 15
- overflow  out  1  a valid code arrived after code_count reached MAX_CODES

## Operation
- Letter map, case-insensitive: A P Z L G I T Y E O X U K S V N = 0..15.
- Separators: 0x0A, 0x0D, 0x20, ',', ';'. The falling edge of dl_active also acts as a separator.
- Parser states:
  - IDLE: waits for a dl_active rise, then goes to CLEAR.
  - CLEAR: sends MAX_CODES frames {1, i, 33'd0} for i = 0..MAX_CODES-1 on consecutive cycles, then goes to COLLECT. code_count and bad_count reset to 0 and overflow clears on entry.
  - COLLECT: accumulates letter nibbles n0..n7 and a letter count.
    - A non-letter, non-separator byte marks the token invalid; the rest of the token is skipped.
    - A 9th letter also marks the token invalid.
  - EMIT: single cycle, entered on a separator, then returns to COLLECT, or to IDLE if dl_active is low.
- Token resolution at a separator:
  - Empty token: no action.
  - Invalid token, or a letter count other than 6 or 8: bad_count+1.
  - Valid token with code_count = MAX_CODES: overflow set, no frame sent.
  - Otherwise: send frame {1, code_count, 1, len8, addr, cmp, rep}, then code_count+1.
- Decode, with addr as 15 bits (bit 15 implied 1):
  - addr = (n3&7)<<12 | (n5&7)<<8 | (n4&8)<<8 | (n2&7)<<4 | (n1&8)<<4 | (n4&7) | (n3&8).
  - rep = (n1&7)<<4 | (n0&8)<<4 | (n0&7) | (n5&8 for 6-letter; n7&8 for 8-letter).
  - 8-letter: cmp = (n7&7)<<4 | (n6&8)<<4 | (n6&7) | (n5&8).
  - 6-letter: cmp = 0, compare enable = 0.
- A dl_active rise during COLLECT or EMIT aborts the partial token without counting it and restarts CLEAR.
- A dl_wr strobe while dl_wait = 1 is dropped.

## Timing
- Reset values: code = 0, dl_wait = 0, code_count = 0, bad_count = 0, overflow = 0, state IDLE, token cleared.
- All outputs are registered. code[37] is high for exactly one cycle per frame; code = 0 on every other cycle.
- CLEAR: dl_active sampled high (previously low) at edge N gives clear frames at cycles N+1..N+MAX_CODES. dl_wait is high over exactly those cycles.
- A separator byte accepted at edge N gives its code frame in cycle N+1. code_count updates at the same edge the frame appears.
- dl_wait is high during EMIT, so back-to-back separators each cost one stall cycle.
- dl_wr coincident with the dl_active fall: the byte is processed first, and the flush separator is handled on the next cycle.
- Asserting reset_n low mid-frame forces code = 0 immediately (asynchronous) and abandons any sequence.

## Test plan
- Reset then dl_active rise with MAX_CODES = 9 -> nine frames, indices 0..8, code[32:0] = 0 on consecutive cycles; dl_wait high for exactly 9 cycles.
- Stream "SXIOPO\n" -> one frame: index 0, enable 1, compare enable 0, addr 0x11D9, cmp 0x00, rep 0xAD, one cycle after the '\n'.
- Stream "pppppppp" then dl_active fall -> frame: addr 0x1111, compare enable 1, cmp 0x11, rep 0x11; code_count = 1.
- Stream "SXIOP\nSXIQPO\nAAAAAAAAA\n" -> no frames; bad_count = 3.
- Eleven valid codes with MAX_CODES = 9 -> nine frames, indices 0..8; overflow = 1; code_count = 9.
- reset_n low during the third clear frame -> code = 0 that cycle, all counters 0; no further frames until the next dl_active rise.
